// File: rtl/adc_spi_reader.sv
// adc_spi_reader: runs a 16-clock serial ADC frame every SAMPLE_PERIOD clocks and publishes sample bits [11:2].
// Result and strobe arrive 32*CLK_DIV cycles after cs_n falls; no backpressure. `ADC_AVG_EN: publish the mean of 4 frames.
module adc_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sdata,
    output logic       cs_n,
    output logic       sclk,
    output logic [9:0] adc_measure,
    output logic       measure_valid,
    output logic       busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_edge;
    logic [PER_W-1:0] r_per;
    logic             r_sclk;
    logic [10:0]      r_shift;
    logic [9:0]       r_meas;
    logic             r_vld;
    logic             w_div_tc;
    logic             w_last;
    logic             w_per_run;

    assign w_div_tc  = (r_state == S_CONVERT) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last    = w_div_tc && (r_edge == 5'd31);
    assign w_per_run = (r_state != S_IDLE) || enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable && (r_per == '0)) w_state_nxt = S_CONVERT;
            S_CONVERT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cs_n          = (r_state != S_CONVERT);
        busy          = (r_state == S_CONVERT);
        sclk          = r_sclk;
        measure_valid = r_vld;
        adc_measure   = r_meas;
    end

    // Period counter keeps running through a frame so frame starts stay SAMPLE_PERIOD apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_per   <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_sclk  <= 1'b1;
            r_shift <= '0;
        end else begin
            if (w_per_run) begin
                r_per <= (r_per == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : r_per + 1'b1;
            end
            if (r_state == S_CONVERT) begin
                r_div <= w_div_tc ? '0 : r_div + 1'b1;
                if (w_div_tc) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 5'd1;
                    // Odd edges are rising; leading zero bits simply shift out of the top.
                    if (r_edge[0]) r_shift <= {r_shift[9:0], sdata};
                end
            end else begin
                r_div  <= '0;
                r_edge <= '0;
                r_sclk <= 1'b1;
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [11:0] w_sample;
    logic [13:0] w_sum;
    logic [13:0] r_acc;
    logic [1:0]  r_fcnt;

    assign w_sample = {r_shift, sdata};
    assign w_sum    = r_acc + {2'b00, w_sample};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_fcnt <= '0;
            r_meas <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_last) begin
                r_fcnt <= r_fcnt + 2'd1;
                if (r_fcnt == 2'd3) begin
                    r_meas <= w_sum[13:4];
                    r_vld  <= 1'b1;
                    r_acc  <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end
`else
    // The bit arriving on the last rising edge is sample bit 0, which the 10-bit result drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meas <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_last;
            if (w_last) r_meas <= r_shift[10:1];
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: table-driven frames, enable/reset corner sequences, and a randomized run against a frame-timing model.
module tb_adc_spi_reader;
    localparam int D    = 2;
    localparam int P    = 100;
    localparam int CONV = 32 * D;
`ifdef ADC_AVG_EN
    localparam int EXP_DROP_PULSES = 0;
`else
    localparam int EXP_DROP_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sdata = 1'b0;
    logic       cs_n;
    logic       sclk;
    logic [9:0] adc_measure;
    logic       measure_valid;
    logic       busy;

    adc_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
        .cs_n(cs_n), .sclk(sclk), .adc_measure(adc_measure),
        .measure_valid(measure_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [15:0] wq[$];

    // ADC model: one queued word per frame, next bit presented on each sclk falling edge.
    int          adc_idx = 0;
    int          bitn    = -1;
    logic [15:0] adc_word = '0;
    always @(negedge cs_n) begin
        adc_word = (adc_idx < wq.size()) ? wq[adc_idx] : 16'h0000;
        adc_idx++;
        bitn = 15;
    end
    always @(negedge sclk) begin
        if (!cs_n && bitn >= 0) begin
            sdata = adc_word[bitn];
            bitn--;
        end
    end

    // Reference: m_t is cycles since cs_n fell (-1 when idle); m_per is the frame-phase count.
    int          m_t = -1;
    int          m_per = 0;
    int          m_frames = 0;
    logic [11:0] m_samp = '0;
    logic [9:0]  m_meas = '0;
    logic        m_vld = 1'b0;
    int          m_acc = 0;
    int          m_cnt = 0;

    task automatic model_step();
        bit active;
        if (reset) begin
            m_t = -1; m_per = 0; m_meas = '0; m_vld = 1'b0; m_acc = 0; m_cnt = 0;
        end else begin
            active = (m_t >= 0);
            m_vld  = 1'b0;
            if (m_t == CONV) m_t = -1;
            else if (m_t >= 0) m_t++;
            else if (enable && m_per == 0) begin
                m_t    = 0;
                m_samp = (m_frames < wq.size()) ? wq[m_frames][11:0] : 12'h000;
                m_frames++;
            end
            if (active || enable) m_per = (m_per + 1) % P;
            if (m_t == CONV) begin
`ifdef ADC_AVG_EN
                m_acc += int'(m_samp);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_meas = 10'(m_acc / 16);
                    m_vld  = 1'b1;
                    m_acc  = 0;
                    m_cnt  = 0;
                end
`else
                m_meas = 10'(int'(m_samp) / 4);
                m_vld  = 1'b1;
`endif
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic e_low;
        logic e_sclk;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        e_low  = (m_t >= 0) && (m_t < CONV);
        e_sclk = e_low ? (((m_t / D) % 2) == 0) : 1'b1;
        check("model_cs_n", cs_n, !e_low);
        check("model_busy", busy, e_low);
        check("model_sclk", sclk, e_sclk);
        check("model_valid", measure_valid, m_vld);
        check("model_measure", adc_measure, m_meas);
    endtask

    task automatic run_frame(output int low, output int pulses, output logic vld,
                             output logic [9:0] meas, output int fall_at, output bit ok);
        int   n = 0;
        logic prev_sclk;
        ok = 0; low = 0; pulses = 0; vld = 1'b0; meas = '0; fall_at = 0;
        while (cs_n && n < 400) begin
            cycle();
            n++;
        end
        check("frame_start", cs_n, 1'b0);
        if (cs_n) return;
        fall_at   = cyc;
        prev_sclk = sclk;
        while (!cs_n && low < 400) begin
            low++;
            cycle();
            if (sclk && !prev_sclk) pulses++;
            prev_sclk = sclk;
        end
        vld  = measure_valid;
        meas = adc_measure;
        ok   = 1;
    endtask

    typedef struct {
        logic [15:0] word;
        logic        exp_vld;
        logic [9:0]  exp_meas;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         low, pulses, fall, prev_fall, n, falls;
        logic       v, prev;
        logic [9:0] me;
        bit         ok;

`ifdef ADC_AVG_EN
        tbl.push_back('{16'h0100, 1'b0, 10'h000});
        tbl.push_back('{16'h0200, 1'b0, 10'h000});
        tbl.push_back('{16'h0300, 1'b0, 10'h000});
        tbl.push_back('{16'h0400, 1'b1, 10'h0A0});
        tbl.push_back('{16'hFFFF, 1'b0, 10'h0A0});
        tbl.push_back('{16'hFFFF, 1'b0, 10'h0A0});
        tbl.push_back('{16'hFFFF, 1'b0, 10'h0A0});
        tbl.push_back('{16'hFFFF, 1'b1, 10'h3FF});
`else
        tbl.push_back('{16'h0ABC, 1'b1, 10'h2AF});
        tbl.push_back('{16'hFFFF, 1'b1, 10'h3FF});
        tbl.push_back('{16'h0000, 1'b1, 10'h000});
        tbl.push_back('{16'hF123, 1'b1, 10'h048});
        tbl.push_back('{16'h0555, 1'b1, 10'h155});
`endif
        foreach (tbl[i]) wq.push_back(tbl[i].word);
        wq.push_back(16'h0ABC);  // frame interrupted by enable drop
        wq.push_back(16'h0DEF);  // resumed frame, aborted by reset
        for (int i = 0; i < 100; i++) wq.push_back(16'($urandom));

        reset = 1'b1;
        enable = 1'b0;
        repeat (3) cycle();
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", measure_valid, 1'b0);
        check("rst_measure", adc_measure, 10'h000);
        reset  = 1'b0;
        enable = 1'b1;

        prev_fall = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            run_frame(low, pulses, v, me, fall, ok);
            if (ok) begin
                check("tbl_cs_low_cycles", 16'(low), 16'(CONV));
                check("tbl_sclk_pulses", 16'(pulses), 16'd16);
                check("tbl_valid_at_cs_rise", v, tbl[i].exp_vld);
                check("tbl_measure", me, tbl[i].exp_meas);
                if (i > 0) check("tbl_frame_period", 16'(fall - prev_fall), 16'(P));
                prev_fall = fall;
            end
        end

        // Drop enable just after edge 10 of a frame.
        n = 0;
        while (cs_n && n < 400) begin cycle(); n++; end
        check("drop_frame_start", cs_n, 1'b0);
        repeat (11 * D) cycle();
        enable = 1'b0;
        pulses = 0; falls = 0; prev = cs_n;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (measure_valid) pulses++;
            if (prev && !cs_n) falls++;
            prev = cs_n;
        end
        check("drop_valid_pulses", 16'(pulses), 16'(EXP_DROP_PULSES));
        check("drop_no_new_frame", 16'(falls), 16'd0);
        check("drop_cs_idle", cs_n, 1'b1);

        // Phase held at 66 while disabled, so 34 more counts wrap it and the 35th cycle starts a frame.
        enable = 1'b1;
        repeat (34) cycle();
        check("resume_not_early", cs_n, 1'b1);
        cycle();
        check("resume_retained_phase", cs_n, 1'b0);

        // One-cycle reset at edge 20 of the resumed frame.
        repeat (21 * D) cycle();
        reset = 1'b1;
        cycle();
        check("midrst_cs_n", cs_n, 1'b1);
        check("midrst_sclk", sclk, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_measure", adc_measure, 10'h000);
        check("midrst_valid", measure_valid, 1'b0);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (measure_valid) pulses++;
        end
        check("midrst_no_partial", 16'(pulses), 16'd0);

        // Randomized enable toggling with rare resets, checked every cycle by the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
